// File: rtl/fft_bin_streamer.sv
`default_nettype none
// ============================================================================
// Module      : fft_bin_streamer
// Description : Captures a parallel FFT result frame on fft_out_valid and
//               streams it one bin per beat over a valid/ready interface,
//               bin 0 first. Frames arriving mid-stream are dropped and
//               counted.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_bin_streamer #(
    parameter int SAMPLES = 16,
    parameter int WIDTH   = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fft_out_valid,
    input  logic [WIDTH-1:0]           fft_outputs [SAMPLES],
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [WIDTH-1:0]           m_data,
    output logic [$clog2(SAMPLES)-1:0] m_index,
    output logic                       m_last,
    output logic                       busy,
    output logic                       overrun,
    output logic [7:0]                 drop_count
);

    localparam int                c_IW       = $clog2(SAMPLES);
    localparam logic [c_IW-1:0]   c_LAST_IDX = c_IW'(SAMPLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [WIDTH-1:0]  r_buf [SAMPLES];
    logic [c_IW-1:0]   r_idx;
    logic              r_overrun;
    logic [7:0]        r_drop_count;

    logic              w_fire;
    logic              w_at_last;
    logic              w_capture;
    logic              w_advance;
    logic              w_drop;

    // Stream outputs come straight from registers so m_valid never depends on m_ready.
    assign m_valid    = (r_state == ST_STREAM);
    assign busy       = (r_state == ST_STREAM);
    assign m_data     = r_buf[r_idx];
    assign m_index    = r_idx;
    assign m_last     = m_valid && w_at_last;
    assign overrun    = r_overrun;
    assign drop_count = r_drop_count;

    assign w_fire    = m_valid && m_ready;
    assign w_at_last = (r_idx == c_LAST_IDX);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic plus capture/advance/drop decisions.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_advance    = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (fft_out_valid) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (w_fire && w_at_last) begin
                    // Final beat accepted: a frame landing now chains with no bubble.
                    if (fft_out_valid) begin
                        w_capture = 1'b1;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_advance = w_fire;
                    w_drop    = fft_out_valid;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Frame buffer: loaded whole on capture, otherwise held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SAMPLES; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_capture) begin
            for (int i = 0; i < SAMPLES; i++) begin
                r_buf[i] <= fft_outputs[i];
            end
        end
    end

    // Bin index: restarts on capture, steps on each accepted non-final beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx <= '0;
        end else if (w_capture) begin
            r_idx <= '0;
        end else if (w_advance) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    // Dropped-frame bookkeeping; sticky flag and saturating counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overrun    <= 1'b0;
            r_drop_count <= 8'd0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
            if (r_drop_count != 8'hFF) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_bin_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_bin_streamer
// Description : Scoreboard bench for fft_bin_streamer. Stimulus pushes the
//               expected beats; a negedge monitor pops and compares on fire.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_bin_streamer;

    localparam int SAMPLES = 16;
    localparam int WIDTH   = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             fft_out_valid = 1'b0;
    logic [WIDTH-1:0] frame [SAMPLES];
    logic             m_valid;
    logic             m_ready = 1'b1;
    logic [WIDTH-1:0] m_data;
    logic [3:0]       m_index;
    logic             m_last;
    logic             busy;
    logic             overrun;
    logic [7:0]       drop_count;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  i;
        logic        l;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    fft_bin_streamer #(.SAMPLES(SAMPLES), .WIDTH(WIDTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .fft_out_valid (fft_out_valid),
        .fft_outputs   (frame),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_index       (m_index),
        .m_last        (m_last),
        .busy          (busy),
        .overrun       (overrun),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Monitor: stability under stall, then scoreboard compare on each fire.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_d;
    logic [3:0]  prev_i;
    logic        prev_l;
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 64'(m_valid), 64'd1);
                chk("stall_data", 64'({m_data, m_index, m_last}), 64'({prev_d, prev_i, prev_l}));
            end
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 64'(m_index), 64'hFFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("beat_data", 64'(m_data), 64'(e.d));
                    chk("beat_index", 64'(m_index), 64'(e.i));
                    chk("beat_last", 64'(m_last), 64'(e.l));
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_d     = m_data;
            prev_i     = m_index;
            prev_l     = m_last;
        end
    end

    task automatic push_frame();
        for (int k = 0; k < SAMPLES; k++) begin
            exp_t e;
            e.d = frame[k];
            e.i = 4'(k);
            e.l = (k == SAMPLES - 1);
            sb.push_back(e);
        end
    endtask

    task automatic set_ramp(input int step, input int offs);
        for (int k = 0; k < SAMPLES; k++) frame[k] = 32'(step * k + offs);
    endtask

    // Drive fft_out_valid for exactly one edge, starting now (posedge+1).
    task automatic pulse_now();
        fft_out_valid = 1'b1;
        @(posedge clk); #1;
        fft_out_valid = 1'b0;
    endtask

    task automatic pulse_frame();
        push_frame();
        @(posedge clk); #1;
        pulse_now();
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy && cycles < 200) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (busy) chk("idle_timeout", 64'(cycles), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        for (int k = 0; k < SAMPLES; k++) frame[k] = '0;

        // Reset state
        #12;
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_m_index", 64'(m_index), 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        do_reset();

        // 1: ramp frame, ready high, exactly 16 cycles
        set_ramp(100, 0);
        m_ready = 1'b1;
        pulse_frame();
        chk("t1_first_valid", 64'(m_valid), 64'd1);
        wait_idle(cyc);
        chk("t1_cycles", 64'(cyc), 64'd16);
        chk("t1_hold_data", 64'(m_data), 64'd1500);
        chk("t1_hold_index", 64'(m_index), 64'd15);
        chk("t1_idle_last", 64'(m_last), 64'd0);
        chk("t1_sb_empty", 64'(sb.size()), 64'd0);

        // 2: backpressure on alternate cycles
        set_ramp(100, 0);
        pulse_frame();
        for (int c = 0; c < 100 && busy; c++) begin
            m_ready = ~m_ready;
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        wait_idle(cyc);
        chk("t2_sb_empty", 64'(sb.size()), 64'd0);

        // 3: overrun drops, frame A unchanged
        set_ramp(100, 0);
        pulse_frame();
        repeat (5) @(posedge clk);
        #0;
        for (int k = 0; k < SAMPLES; k++) frame[k] = 32'd9;
        pulse_now();
        chk("t3_overrun", 64'(overrun), 64'd1);
        chk("t3_drop1", 64'(drop_count), 64'd1);
        repeat (2) @(posedge clk);
        #1 pulse_now();
        repeat (2) @(posedge clk);
        #1 pulse_now();
        wait_idle(cyc);
        chk("t3_drop3", 64'(drop_count), 64'd3);
        chk("t3_sb_empty", 64'(sb.size()), 64'd0);

        // 4: back-to-back frames, no bubble, no drop
        do_reset();
        set_ramp(100, 0);
        pulse_frame();
        repeat (15) @(posedge clk);
        #1;
        for (int k = 0; k < SAMPLES; k++) frame[k] = 32'd7;
        push_frame();
        pulse_now();
        chk("t4_no_bubble", 64'(m_valid), 64'd1);
        chk("t4_b0_index", 64'(m_index), 64'd0);
        wait_idle(cyc);
        chk("t4_cycles", 64'(cyc), 64'd16);
        chk("t4_drop", 64'(drop_count), 64'd0);
        chk("t4_sb_empty", 64'(sb.size()), 64'd0);

        // 5: async reset mid-stream
        set_ramp(100, 0);
        pulse_frame();
        repeat (2) @(posedge clk);
        #1 pulse_now();
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t5_m_valid", 64'(m_valid), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_overrun", 64'(overrun), 64'd0);
        chk("t5_drop", 64'(drop_count), 64'd0);
        chk("t5_m_index", 64'(m_index), 64'd0);
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        set_ramp(3, 1);
        pulse_frame();
        chk("t5_restart_index", 64'(m_index), 64'd0);
        wait_idle(cyc);
        chk("t5_sb_empty", 64'(sb.size()), 64'd0);

        // 6: drop counter saturation while stalled
        set_ramp(11, 5);
        m_ready = 1'b0;
        pulse_frame();
        fft_out_valid = 1'b1;
        repeat (300) @(posedge clk);
        #1 fft_out_valid = 1'b0;
        chk("t6_drop_sat", 64'(drop_count), 64'd255);
        chk("t6_overrun", 64'(overrun), 64'd1);
        chk("t6_stalled_index", 64'(m_index), 64'd0);
        m_ready = 1'b1;
        wait_idle(cyc);
        chk("t6_sb_empty", 64'(sb.size()), 64'd0);
        chk("t6_drop_hold", 64'(drop_count), 64'd255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
